// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes)
// unit producing a HI/LO result pair; one iteration per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multOp,
    input  logic             divOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_acc;     // Booth accumulator, or partial remainder in low WIDTH bits
    logic [WIDTH-1:0] r_q;       // multiplier / quotient shift register
    logic [WIDTH-1:0] r_m;       // multiplicand / divisor magnitude
    logic             r_qm1;
    logic             r_sa;
    logic             r_sq;
    logic             r_dz;
    logic             r_divZero;
    logic [WIDTH-1:0] r_hi, r_lo;

    logic             w_last;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [WIDTH:0]   w_bsum;
    logic [WIDTH:0]   w_rs, w_diff;
    logic [WIDTH-1:0] w_quot, w_rem;

    assign w_last  = (r_cnt == CW'(WIDTH));
    assign w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_comb begin
        w_bsum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_bsum = r_acc + {r_m[WIDTH-1], r_m};
            2'b10:   w_bsum = r_acc - {r_m[WIDTH-1], r_m};
            default: w_bsum = r_acc;
        endcase
    end

    assign w_rs   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_diff = w_rs - {1'b0, r_m};
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign w_quot = r_sq ? (~r_q + 1'b1) : r_q;
    assign w_rem  = r_sa ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (multOp)     w_next = S_MULT;
                else if (divOp) w_next = S_DIV;
            end
            S_MULT: begin
                busy = 1'b1;
                if (w_last) w_next = S_FINISH;
            end
            S_DIV: begin
                busy = 1'b1;
                if (r_dz ? (r_cnt == CW'(1)) : w_last) w_next = S_FINISH;
            end
            default: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_qm1     <= 1'b0;
            r_sa      <= 1'b0;
            r_sq      <= 1'b0;
            r_dz      <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (multOp || divOp) begin
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_qm1     <= 1'b0;
                        r_divZero <= 1'b0;
                        if (multOp) begin
                            r_m  <= a;
                            r_q  <= b;
                            r_dz <= 1'b0;
                        end else begin
                            r_m  <= w_abs_b;
                            r_q  <= w_abs_a;
                            r_sa <= a[WIDTH-1];
                            r_sq <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_dz <= (b == '0);
                        end
                    end
                end
                S_MULT: begin
                    if (w_last) begin
                        r_hi <= r_acc[WIDTH-1:0];
                        r_lo <= r_q;
                    end else begin
                        r_acc <= {w_bsum[WIDTH], w_bsum[WIDTH:1]};
                        r_q   <= {w_bsum[0], r_q[WIDTH-1:1]};
                        r_qm1 <= r_q[0];
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (r_dz) begin
                        // Divide by zero: one wait cycle, HI/LO untouched.
                        if (r_cnt == CW'(1)) r_divZero <= 1'b1;
                        else                 r_cnt     <= r_cnt + 1'b1;
                    end else if (w_last) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_acc <= w_diff[WIDTH] ? {1'b0, w_rs[WIDTH-1:0]} : {1'b0, w_diff[WIDTH-1:0]};
                        r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign divZero = r_divZero;
    assign hi      = r_hi;
    assign lo      = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed checks for mult_div_unit: reset, signed mul/div, divide-by-zero,
// overflow wrap, ignored strobes, mid-operation reset and strobe priority.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         multOp = 1'b0;
    logic         divOp = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, divZero;
    logic [W-1:0] hi, lo;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .multOp(multOp), .divOp(divOp),
        .a(a), .b(b), .busy(busy), .done(done), .divZero(divZero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the sim #1 after the edge on which done was first seen high.
    task automatic wait_done(input string tag, input int exp_lat);
        int  n;
        logic overlap;
        n = 0;
        overlap = 1'b0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (busy && done) overlap = 1'b1;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy_done_overlap"}, {63'd0, overlap}, 64'd0);
    endtask

    // One idle cycle first so a preceding FINISH has returned to IDLE.
    task automatic start(input logic m, input logic d, input logic [W-1:0] aa, input logic [W-1:0] bb);
        tick();
        multOp = m;
        divOp  = d;
        a      = aa;
        b      = bb;
        tick();
        multOp = 1'b0;
        divOp  = 1'b0;
        a      = 32'hDEAD_BEEF;
        b      = 32'h0BAD_F00D;
    endtask

    initial begin
        logic saw_done;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_divzero", 64'(divZero), 64'd0);

        // 7 * -3 = -21
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("mul1_busy", 64'(busy), 64'd1);
        chk("mul1_lo_during_busy", 64'(lo), 64'd0);
        wait_done("mul1", W + 1);
        chk("mul1_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mul1_lo", 64'(lo), 64'hFFFF_FFEB);
        tick();
        chk("mul1_done_one_cycle", 64'(done), 64'd0);

        // -7 / 2 = -3 rem -1
        start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div1_hi_during_busy", 64'(hi), 64'hFFFF_FFFF);
        wait_done("div1", W + 1);
        chk("div1_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div1_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div1_divzero", 64'(divZero), 64'd0);

        // most-negative / -1 wraps
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", W + 1);
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'd0);
        chk("div_ovf_divzero", 64'(divZero), 64'd0);

        // 5 / 0
        start(1'b0, 1'b1, 32'd5, 32'd0);
        wait_done("div0", 2);
        chk("div0_divzero", 64'(divZero), 64'd1);
        chk("div0_hi_kept", 64'(hi), 64'd0);
        chk("div0_lo_kept", 64'(lo), 64'h8000_0000);

        // -5 * -6 = 30; the start clears divZero
        start(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
        chk("mul2_divzero_cleared", 64'(divZero), 64'd0);
        wait_done("mul2", W + 1);
        chk("mul2_hi", 64'(hi), 64'd0);
        chk("mul2_lo", 64'(lo), 64'd30);

        // 0x12345678 * 16, with a second strobe mid-operation that must be ignored
        start(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0010);
        repeat (5) tick();
        multOp = 1'b1;
        a = 32'd3;
        b = 32'd3;
        tick();
        multOp = 1'b0;
        wait_done("mul3", W + 1 - 6);
        chk("mul3_hi", 64'(hi), 64'd1);
        chk("mul3_lo", 64'(lo), 64'h2345_6780);
        tick();
        chk("mul3_no_requeue", 64'(busy), 64'd0);

        // Reset at iteration 10 aborts with no done pulse
        start(1'b1, 1'b0, 32'd100, 32'd200);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        saw_done = done;
        repeat (40) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 64'(saw_done), 64'd0);

        // Both strobes: multiply wins, 6 * -4 = -24
        start(1'b1, 1'b1, 32'd6, 32'hFFFF_FFFC);
        wait_done("both", W + 1);
        chk("both_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("both_lo", 64'(lo), 64'hFFFF_FFE8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
